// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath: sequences each
// instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            Opcode,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  PCWriteCond,
  output logic                  IorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemtoReg,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  RegDst,
  output logic                  ALUSrcA,
  output logic [1:0]            PCSource,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ALUSrcB,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic [3:0]            state,
  output logic [DATA_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t                state_q, state_d;
  logic                  is_sw_q, is_sw_d;
  logic [DATA_WIDTH-1:0] instr_count_q, instr_count_d;

  // Zero feeds the datapath's branch gating, never the sequencing.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      is_sw_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      is_sw_q       <= is_sw_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_sw_d     = is_sw_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        // Remember load vs store here so MEM_ADDR does not depend on Opcode.
        is_sw_d = (Opcode == OP_SW);
        case (Opcode)
          OP_RTYPE:      state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_sw_q ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = I_WB;
      end
      I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_count_d = instr_done ? instr_count_q + DATA_WIDTH'(1) : instr_count_q;
  assign instr_count   = instr_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected traces are
// built from opcode and memory-wait counts, then compared cycle by cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  Opcode = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mw, m2r, irw, rw, rd, asa;
    logic [1:0] pcs, aop, asb;
    logic done, ill;
  } ctl_t;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  ctl_t obs;
  assign obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, instr_done, illegal_op};

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_count = '0;
  bit          pcs3_seen = 1'b0;

  always @(negedge clk) begin
    #2;
    if (PCSource == 2'b11) pcs3_seen = 1'b1;
  end

  // Expected control word for one cycle, straight from the per-state table.
  function automatic ctl_t spec_ctl(input int st, input bit mr, input bit ill);
    ctl_t c;
    c = '0;
    c.st = 4'(st);
    case (st)
      1:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      2:  begin c.asb = 2'b11; c.ill = ill; end
      3:  begin c.asa = 1; c.asb = 2'b10; end
      4:  begin c.mrd = 1; c.iord = 1; end
      5:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
      6:  begin c.mw = 1; c.iord = 1; c.done = mr; end
      7:  begin c.asa = 1; c.aop = 2'b10; end
      8:  begin c.rw = 1; c.rd = 1; c.done = 1; end
      9:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; end
      10: begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
      11: begin c.asa = 1; c.asb = 2'b10; end
      12: begin c.rw = 1; c.done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic step_t mk(input int st, input bit mr);
    step_t s;
    s.st = st;
    s.mr = mr;
    return s;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one whole instruction: fw stalls in FETCH, mw stalls in the data access.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string name);
    step_t q[$];
    ctl_t  exp;
    bit    legal;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) ||
            (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    for (int i = 0; i < fw; i++) q.push_back(mk(1, 1'b0));
    q.push_back(mk(1, 1'b1));
    q.push_back(mk(2, rbit()));
    case (op)
      6'h00: begin q.push_back(mk(7, rbit())); q.push_back(mk(8, rbit())); end
      6'h23: begin
        q.push_back(mk(3, rbit()));
        for (int i = 0; i < mw; i++) q.push_back(mk(4, 1'b0));
        q.push_back(mk(4, 1'b1));
        q.push_back(mk(5, rbit()));
      end
      6'h2b: begin
        q.push_back(mk(3, rbit()));
        for (int i = 0; i < mw; i++) q.push_back(mk(6, 1'b0));
        q.push_back(mk(6, 1'b1));
      end
      6'h04: q.push_back(mk(9, rbit()));
      6'h02: q.push_back(mk(10, rbit()));
      6'h08: begin q.push_back(mk(11, rbit())); q.push_back(mk(12, rbit())); end
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      Opcode    = op;
      mem_ready = q[i].mr;
      Zero      = rbit();
      #1;
      exp = spec_ctl(q[i].st, q[i].mr, !legal);
      n_total++;
      if (obs !== exp)
        $display("FAIL %s ctl step %0d: got %h required %h", name, i, obs, exp);
      else n_pass++;
      n_total++;
      if (instr_count !== exp_count)
        $display("FAIL %s count step %0d: got %0d required %0d", name, i, instr_count, exp_count);
      else n_pass++;
      if (exp.done) exp_count++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (obs !== ctl_t'('0) || instr_count !== 32'd0)
      $display("FAIL reset_hold: got ctl %h count %0d required 0 0", obs, instr_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (obs !== ctl_t'('0))
      $display("FAIL reset_release_idle: got %h required 0", obs);
    else n_pass++;
    exp_count = '0;
  endtask

  task automatic test_rtype();      run_instr(6'h00, 0, 0, "rtype");    endtask
  task automatic test_lw_stall();   run_instr(6'h23, 0, 2, "lw_stall"); endtask
  task automatic test_sw_fetch();   run_instr(6'h2b, 3, 0, "sw_fetch"); endtask
  task automatic test_illegal();    run_instr(6'h3f, 0, 0, "illegal");  endtask

  task automatic test_branch_jump();
    run_instr(6'h04, 0, 0, "beq");
    run_instr(6'h02, 0, 0, "j");
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_count_settle();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_total++;
    if (state !== 4'd1 || instr_count !== exp_count)
      $display("FAIL count_settle: got state %0d count %0d required 1 %0d",
               state, instr_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int seq [4] = '{1, 2, 3, 4};
    bit mrs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Opcode    = 6'h23;
      mem_ready = mrs[i];
      #1;
      n_total++;
      if (state !== 4'(seq[i]))
        $display("FAIL abort_seq step %0d: got %0d required %0d", i, state, seq[i]);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if (state !== 4'd0 || instr_count !== 32'd0 || MemRead !== 1'b0 || IorD !== 1'b0)
      $display("FAIL abort_reset: got state %0d count %0d MemRead %b required 0 0 0",
               state, instr_count, MemRead);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    run_instr(6'h08, 1, 0, "after_abort");
  endtask

  task automatic test_pcsource_never3();
    n_total++;
    if (pcs3_seen !== 1'b0)
      $display("FAIL pcsource_11: got seen=%b required 0", pcs3_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_fetch();
    test_branch_jump();
    test_illegal();
    test_random();
    test_count_settle();
    test_reset_midflight();
    test_count_settle();
    test_pcsource_never3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
